// File: rtl/dir_memory_ctrl_if.sv
// Request/response bundle between the cache controllers and the directory memory.
// The master side issues requests and consumes responses; the slave side is the memory.
interface dir_memory_ctrl_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 4,
  parameter int NPROC  = 3,
  parameter int PROC_W = (NPROC > 1) ? $clog2(NPROC) : 1
);
  logic              reqValid;
  logic              reqReady;
  logic [1:0]        reqOp;
  logic [ADDR_W-1:0] reqAddr;
  logic [DATA_W-1:0] reqData;
  logic [PROC_W-1:0] reqProc;
  logic              respValid;
  logic              respReady;
  logic [DATA_W-1:0] respData;
  logic [NPROC-1:0]  respMask;
  logic [2:0]        respStatus;

  modport master (
    output reqValid, reqOp, reqAddr, reqData, reqProc, respReady,
    input  reqReady, respValid, respData, respMask, respStatus
  );

  modport slave (
    input  reqValid, reqOp, reqAddr, reqData, reqProc, respReady,
    output reqReady, respValid, respData, respMask, respStatus
  );
endinterface

// File: rtl/dir_memory_ctrl.sv
// Main memory with a per-line MSI directory. Serves one request at a time
// (read-shared, read-exclusive, writeback) through IDLE->LOOKUP->WAIT->RESP and
// reports which processors the requester must invalidate or recall.
module dir_memory_ctrl #(
  parameter int ADDR_W  = 4,
  parameter int DATA_W  = 4,
  parameter int DEPTH   = 8,
  parameter int NPROC   = 3,
  parameter int LATENCY = 2,
  localparam int PROC_W = (NPROC > 1) ? $clog2(NPROC) : 1
) (
  input logic clk,
  input logic rst,
  dir_memory_ctrl_if.slave bus
);

  localparam int IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W     = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int WAIT_LOAD = (LATENCY > 0) ? LATENCY - 1 : 0;

  localparam logic [1:0] OP_READ_S = 2'b00;
  localparam logic [1:0] OP_READ_X = 2'b01;
  localparam logic [1:0] OP_WB     = 2'b10;

  localparam logic [2:0] ST_OK     = 3'b000;
  localparam logic [2:0] ST_MISS   = 3'b001;
  localparam logic [2:0] ST_RECALL = 3'b010;
  localparam logic [2:0] ST_ERR    = 3'b011;

  typedef enum logic [1:0] {IDLE, LOOKUP, WAIT, RESP} stateT;
  typedef enum logic [1:0] {DIR_I, DIR_S, DIR_M} dirT;

  stateT state, nextState;
  logic [CNT_W-1:0] waitCnt;

  logic [1:0]        reqOpQ;
  logic [ADDR_W-1:0] reqAddrQ;
  logic [DATA_W-1:0] reqDataQ;
  logic [PROC_W-1:0] reqProcQ;

  logic [ADDR_W-1:0] tagMem   [DEPTH];
  logic [DATA_W-1:0] dataMem  [DEPTH];
  dirT               dirState [DEPTH];
  logic [NPROC-1:0]  sharers  [DEPTH];

  logic              hit;
  logic [IDX_W-1:0]  hitIdx;

  logic              respValidQ;
  logic [DATA_W-1:0] respDataQ;
  logic [NPROC-1:0]  respMaskQ;
  logic [2:0]        respStatusQ;

  logic              procOk;
  logic [NPROC-1:0]  reqBit;
  logic [DATA_W-1:0] curData;
  dirT               curState;
  logic [NPROC-1:0]  curSharers;
  logic [DATA_W-1:0] outData;
  logic [NPROC-1:0]  outMask;
  logic [2:0]        outStatus;
  logic              wrData;
  logic              wrDir;
  logic [DATA_W-1:0] newData;
  dirT               newState;
  logic [NPROC-1:0]  newSharers;
  logic              reqReadyInt;
  logic              enterResp;

  assign reqReadyInt    = (state == IDLE) && !rst;
  assign bus.reqReady   = reqReadyInt;
  assign bus.respValid  = respValidQ;
  assign bus.respData   = respDataQ;
  assign bus.respMask   = respMaskQ;
  assign bus.respStatus = respStatusQ;

  // Tag match on the latched address; scanning downward leaves the lowest matching index.
  always_comb begin
    hit    = 1'b0;
    hitIdx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (reqAddrQ != '0 && tagMem[i] == reqAddrQ) begin
        hit    = 1'b1;
        hitIdx = IDX_W'(i);
      end
    end
  end

  // Protocol decision: response fields and the line/directory update to commit on entering RESP.
  always_comb begin
    procOk     = (int'(reqProcQ) < NPROC);
    reqBit     = procOk ? (NPROC'(1) << reqProcQ) : '0;
    curData    = dataMem[hitIdx];
    curState   = dirState[hitIdx];
    curSharers = sharers[hitIdx];
    outData    = '0;
    outMask    = '0;
    outStatus  = ST_MISS;
    wrData     = 1'b0;
    wrDir      = 1'b0;
    newData    = curData;
    newState   = curState;
    newSharers = curSharers;
    if (hit) begin
      outStatus = ST_ERR;
      if (procOk) begin
        case (reqOpQ)
          OP_READ_S: begin
            if (curState == DIR_M && curSharers != reqBit) begin
              outStatus = ST_RECALL;
              outMask   = curSharers;
            end else begin
              outStatus  = ST_OK;
              outData    = curData;
              wrDir      = 1'b1;
              newSharers = curSharers | reqBit;
              newState   = (curState == DIR_M) ? DIR_M : DIR_S;
            end
          end
          OP_READ_X: begin
            if (curState == DIR_M && curSharers != reqBit) begin
              outStatus = ST_RECALL;
              outMask   = curSharers;
            end else begin
              outStatus  = ST_OK;
              outData    = curData;
              outMask    = curSharers & ~reqBit;
              wrDir      = 1'b1;
              newSharers = reqBit;
              newState   = DIR_M;
            end
          end
          OP_WB: begin
            if (curState == DIR_M && curSharers == reqBit) begin
              outStatus  = ST_OK;
              wrData     = 1'b1;
              newData    = reqDataQ;
              wrDir      = 1'b1;
              newSharers = '0;
              newState   = DIR_I;
            end
          end
          default: outStatus = ST_ERR;
        endcase
      end
    end
  end

  // Next-state logic; requests arriving outside IDLE are simply not looked at.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (bus.reqValid && reqReadyInt) nextState = LOOKUP;
      LOOKUP:  nextState = (!hit || LATENCY == 0) ? RESP : WAIT;
      WAIT:    if (waitCnt == '0) nextState = RESP;
      RESP:    if (bus.respReady) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  assign enterResp = (state != RESP) && (nextState == RESP);

  // State register, latency counter and request capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      waitCnt  <= '0;
      reqOpQ   <= '0;
      reqAddrQ <= '0;
      reqDataQ <= '0;
      reqProcQ <= '0;
    end else begin
      state <= nextState;
      if (state == IDLE && nextState == LOOKUP) begin
        reqOpQ   <= bus.reqOp;
        reqAddrQ <= bus.reqAddr;
        reqDataQ <= bus.reqData;
        reqProcQ <= bus.reqProc;
      end
      if (state == LOOKUP) begin
        waitCnt <= CNT_W'(WAIT_LOAD);
      end else if (state == WAIT && waitCnt != '0) begin
        waitCnt <= waitCnt - 1'b1;
      end
    end
  end

  // Memory, directory and response registers all commit together on the edge into RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tagMem[i]   <= ADDR_W'(i + 1);
        dataMem[i]  <= DATA_W'(i + 1);
        dirState[i] <= DIR_I;
        sharers[i]  <= '0;
      end
      respValidQ  <= 1'b0;
      respDataQ   <= '0;
      respMaskQ   <= '0;
      respStatusQ <= '0;
    end else if (enterResp) begin
      respValidQ  <= 1'b1;
      respDataQ   <= outData;
      respMaskQ   <= outMask;
      respStatusQ <= outStatus;
      if (wrData) dataMem[hitIdx] <= newData;
      if (wrDir) begin
        dirState[hitIdx] <= newState;
        sharers[hitIdx]  <= newSharers;
      end
    end else if (state == RESP && bus.respReady) begin
      respValidQ  <= 1'b0;
      respDataQ   <= '0;
      respMaskQ   <= '0;
      respStatusQ <= '0;
    end
  end

endmodule

// File: tb/tb_dir_memory_ctrl.sv
// Directed scoreboard bench for dir_memory_ctrl: the driver pushes the hand-computed
// response for each request and a negedge monitor pops and compares each new response.
module tb_dir_memory_ctrl;
  localparam int ADDR_W   = 4;
  localparam int DATA_W   = 4;
  localparam int DEPTH    = 8;
  localparam int NPROC    = 3;
  localparam int LATENCY  = 2;
  localparam int HIT_LAT  = LATENCY + 2;
  localparam int MISS_LAT = 2;
  localparam int MAX_WAIT = 40;

  localparam logic [2:0] ST_OK     = 3'b000;
  localparam logic [2:0] ST_MISS   = 3'b001;
  localparam logic [2:0] ST_RECALL = 3'b010;
  localparam logic [2:0] ST_ERR    = 3'b011;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [NPROC-1:0]  mask;
    logic [2:0]        status;
  } expT;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checkCount = 0;
  int   failCount  = 0;
  expT  expQ[$];
  expT  monExp;
  logic prevValid = 1'b0;

  dir_memory_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NPROC(NPROC)) bus ();

  dir_memory_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .NPROC(NPROC), .LATENCY(LATENCY)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Monitor: every fresh response is matched against the oldest queued expectation.
  always @(negedge clk) begin
    if (rst) begin
      prevValid <= 1'b0;
    end else begin
      if (bus.respValid && !prevValid) begin
        if (expQ.size() == 0) begin
          checkCount++;
          failCount++;
          $display("[TB] FAIL unexpectedResp: got a response, expected none");
        end else begin
          monExp = expQ.pop_front();
          checkOutput("respData", 32'(bus.respData), 32'(monExp.data));
          checkOutput("respMask", 32'(bus.respMask), 32'(monExp.mask));
          checkOutput("respStatus", 32'(bus.respStatus), 32'(monExp.status));
        end
      end
      prevValid <= bus.respValid;
    end
  end

  // Drive one request, check its latency, optionally stall the response, then consume it.
  task automatic applyStimulus(input logic [1:0] op, input logic [ADDR_W-1:0] addr,
                               input logic [DATA_W-1:0] data, input logic [1:0] proc,
                               input logic [DATA_W-1:0] expData, input logic [NPROC-1:0] expMask,
                               input logic [2:0] expStatus, input int expLat, input int holdCycles);
    int n;
    int edges;
    expT e;
    e.data = expData;
    e.mask = expMask;
    e.status = expStatus;
    expQ.push_back(e);
    n = 0;
    @(negedge clk);
    while (!bus.reqReady && n < MAX_WAIT) begin
      @(negedge clk);
      n++;
    end
    checkOutput("reqReadyBeforeIssue", 32'(bus.reqReady), 32'd1);
    bus.reqOp    = op;
    bus.reqAddr  = addr;
    bus.reqData  = data;
    bus.reqProc  = proc;
    bus.reqValid = 1'b1;
    @(posedge clk);
    #1 bus.reqValid = 1'b0;
    edges = 1;
    while (!bus.respValid && edges < MAX_WAIT) begin
      @(posedge clk);
      #1 edges++;
    end
    checkOutput("latency", 32'(edges), 32'(expLat));
    if (bus.respValid) begin
      for (int c = 0; c < holdCycles; c++) begin
        @(negedge clk);
        bus.reqOp    = 2'b00;
        bus.reqAddr  = 4'd7;
        bus.reqProc  = 2'd1;
        bus.reqValid = 1'b1;
        checkOutput("holdValid", 32'(bus.respValid), 32'd1);
        checkOutput("holdData", 32'(bus.respData), 32'(expData));
        checkOutput("holdMask", 32'(bus.respMask), 32'(expMask));
        checkOutput("holdStatus", 32'(bus.respStatus), 32'(expStatus));
        checkOutput("holdReqReady", 32'(bus.reqReady), 32'd0);
      end
      @(negedge clk);
      bus.respReady = 1'b1;
      @(posedge clk);
      #1;
      bus.respReady = 1'b0;
      bus.reqValid  = 1'b0;
      checkOutput("respValidCleared", 32'(bus.respValid), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.reqValid  = 1'b0;
    bus.reqOp     = '0;
    bus.reqAddr   = '0;
    bus.reqData   = '0;
    bus.reqProc   = '0;
    bus.respReady = 1'b0;
    #12;
    checkOutput("resetReqReady", 32'(bus.reqReady), 32'd0);
    checkOutput("resetRespValid", 32'(bus.respValid), 32'd0);
    checkOutput("resetRespData", 32'(bus.respData), 32'd0);
    checkOutput("resetRespMask", 32'(bus.respMask), 32'd0);
    checkOutput("resetRespStatus", 32'(bus.respStatus), 32'd0);
    @(negedge clk) rst = 1'b0;
    #1 checkOutput("idleReqReady", 32'(bus.reqReady), 32'd1);

    // Sharing, upgrade, recall and writeback on line with tag 1
    applyStimulus(2'b00, 4'd1, 4'd0, 2'd0, 4'd1, 3'b000, ST_OK,     HIT_LAT, 0);
    applyStimulus(2'b00, 4'd1, 4'd0, 2'd1, 4'd1, 3'b000, ST_OK,     HIT_LAT, 0);
    applyStimulus(2'b01, 4'd1, 4'd0, 2'd2, 4'd1, 3'b011, ST_OK,     HIT_LAT, 0);
    applyStimulus(2'b00, 4'd1, 4'd0, 2'd0, 4'd0, 3'b100, ST_RECALL, HIT_LAT, 0);
    applyStimulus(2'b01, 4'd1, 4'd0, 2'd1, 4'd0, 3'b100, ST_RECALL, HIT_LAT, 0);
    applyStimulus(2'b10, 4'd1, 4'd5, 2'd0, 4'd0, 3'b000, ST_ERR,    HIT_LAT, 0);
    applyStimulus(2'b10, 4'd1, 4'd9, 2'd2, 4'd0, 3'b000, ST_OK,     HIT_LAT, 0);
    applyStimulus(2'b00, 4'd1, 4'd0, 2'd0, 4'd9, 3'b000, ST_OK,     HIT_LAT, 0);

    // Misses, reserved op and out-of-range processor
    applyStimulus(2'b00, 4'd0,  4'd0, 2'd0, 4'd0, 3'b000, ST_MISS, MISS_LAT, 0);
    applyStimulus(2'b00, 4'd15, 4'd0, 2'd0, 4'd0, 3'b000, ST_MISS, MISS_LAT, 0);
    applyStimulus(2'b11, 4'd2,  4'd0, 2'd0, 4'd0, 3'b000, ST_ERR,  HIT_LAT,  0);
    applyStimulus(2'b00, 4'd2,  4'd0, 2'd3, 4'd0, 3'b000, ST_ERR,  HIT_LAT,  0);

    // Owner re-read keeps M, owner writeback, then exclusive from idle line
    applyStimulus(2'b01, 4'd3, 4'd0, 2'd1, 4'd3, 3'b000, ST_OK, HIT_LAT, 0);
    applyStimulus(2'b00, 4'd3, 4'd0, 2'd1, 4'd3, 3'b000, ST_OK, HIT_LAT, 0);
    applyStimulus(2'b10, 4'd3, 4'd4, 2'd1, 4'd0, 3'b000, ST_OK, HIT_LAT, 0);
    applyStimulus(2'b01, 4'd3, 4'd0, 2'd0, 4'd4, 3'b000, ST_OK, HIT_LAT, 0);

    // Stalled response with a competing request held on the bus
    applyStimulus(2'b00, 4'd5, 4'd0, 2'd0, 4'd5, 3'b000, ST_OK, HIT_LAT, 5);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1 checkOutput("noExtraResp", 32'(bus.respValid), 32'd0);
    end

    // Reset while waiting must leave the line untouched
    @(negedge clk);
    bus.reqOp    = 2'b01;
    bus.reqAddr  = 4'd6;
    bus.reqProc  = 2'd0;
    bus.reqValid = 1'b1;
    @(posedge clk);
    #1 bus.reqValid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    checkOutput("abortRespValid", 32'(bus.respValid), 32'd0);
    checkOutput("abortRespData", 32'(bus.respData), 32'd0);
    checkOutput("abortRespMask", 32'(bus.respMask), 32'd0);
    checkOutput("abortRespStatus", 32'(bus.respStatus), 32'd0);
    checkOutput("abortReqReady", 32'(bus.reqReady), 32'd0);
    @(negedge clk) rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1 checkOutput("abortNoResp", 32'(bus.respValid), 32'd0);
    end
    applyStimulus(2'b00, 4'd6, 4'd0, 2'd1, 4'd6, 3'b000, ST_OK, HIT_LAT, 0);
    applyStimulus(2'b01, 4'd6, 4'd0, 2'd0, 4'd6, 3'b010, ST_OK, HIT_LAT, 0);

    repeat (4) @(posedge clk);
    #1 checkOutput("scoreboardEmpty", 32'(expQ.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end
endmodule
